// File: rtl/abs_diff_err_sweep.sv
// Exhaustive error sweep for an external combinational approximate |a-b| circuit.
// Latency: 2^(2*OP_W)+1 cycles from the start edge to the done pulse (4097 for OP_W=6).
// Backpressure: none. start is ignored while busy; the external DUT must respond in the same cycle.
module abs_diff_err_sweep #(
  parameter int OP_W  = 6,
  parameter int CNT_W = 13,
  parameter int SUM_W = 18
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic [2*OP_W-1:0]   dut_pi,
  input  logic [OP_W-1:0]     dut_po,
  output logic                busy,
  output logic                done,
  output logic [CNT_W-1:0]    err_count,
  output logic [SUM_W-1:0]    err_sum,
  output logic [OP_W-1:0]     max_err,
  output logic [2*OP_W-1:0]   wce_vec
);

  localparam int VEC_W = 2 * OP_W;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              w_accept;   // start taken this edge: clear results, begin at vector 0
  logic              w_sweep;    // sample the current vector into stage 1
  logic              w_last;     // current vector is the final one, hold dut_pi
  logic              w_drain;    // final sample is being accumulated

  logic [VEC_W-1:0]  r_dut_pi;
  logic              r_busy;
  logic              r_done;

  logic              r_s1_vld;
  logic [OP_W-1:0]   r_s1_err;
  logic [VEC_W-1:0]  r_s1_vec;

  logic [CNT_W-1:0]  r_err_count;
  logic [SUM_W-1:0]  r_err_sum;
  logic [OP_W-1:0]   r_max_err;
  logic [VEC_W-1:0]  r_wce_vec;

  logic [OP_W-1:0]   w_a;
  logic [OP_W-1:0]   w_b;
  logic [OP_W-1:0]   w_exact;
  logic [OP_W-1:0]   w_err;

  // Exact |a-b| of the current vector and its distance from the DUT answer.
  always_comb begin
    w_a     = r_dut_pi[OP_W-1:0];
    w_b     = r_dut_pi[VEC_W-1:OP_W];
    w_exact = (w_a >= w_b) ? (w_a - w_b) : (w_b - w_a);
    w_err   = (w_exact >= dut_po) ? (w_exact - dut_po) : (dut_po - w_exact);
  end

  // Sequencer state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state and per-edge control strobes; DONE accepts start exactly like IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_sweep     = 1'b0;
    w_last      = 1'b0;
    w_drain     = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_accept    = 1'b1;
          w_state_nxt = S_SWEEP;
        end
      end
      S_SWEEP: begin
        w_sweep = 1'b1;
        if (r_dut_pi == {VEC_W{1'b1}}) begin
          w_last      = 1'b1;
          w_state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_drain     = 1'b1;
        w_state_nxt = S_DONE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Vector counter, busy flag and the single-cycle done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dut_pi <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= w_drain;
      if (w_accept) begin
        r_dut_pi <= '0;
        r_busy   <= 1'b1;
      end else if (w_sweep && !w_last) begin
        r_dut_pi <= r_dut_pi + 1'b1;
      end
      if (w_drain) r_busy <= 1'b0;
    end
  end

  // Stage 1: capture the per-vector error alongside the vector that produced it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
      r_s1_err <= '0;
      r_s1_vec <= '0;
    end else if (w_sweep) begin
      r_s1_vld <= 1'b1;
      r_s1_err <= w_err;
      r_s1_vec <= r_dut_pi;
    end else begin
      r_s1_vld <= 1'b0;
    end
  end

  // Stage 2: accumulate metrics; strict compare keeps the earliest worst-case vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
      r_err_sum   <= '0;
      r_max_err   <= '0;
      r_wce_vec   <= '0;
    end else if (w_accept) begin
      r_err_count <= '0;
      r_err_sum   <= '0;
      r_max_err   <= '0;
      r_wce_vec   <= '0;
    end else if (r_s1_vld) begin
      r_err_sum   <= r_err_sum + {{(SUM_W-OP_W){1'b0}}, r_s1_err};
      r_err_count <= r_err_count + {{(CNT_W-1){1'b0}}, (r_s1_err != '0)};
      if (r_s1_err > r_max_err) begin
        r_max_err <= r_s1_err;
        r_wce_vec <= r_s1_vec;
      end
    end
  end

  assign dut_pi    = r_dut_pi;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err_count = r_err_count;
  assign err_sum   = r_err_sum;
  assign max_err   = r_max_err;
  assign wce_vec   = r_wce_vec;

endmodule

// File: tb/tb_abs_diff_err_sweep.sv
// Directed bench for abs_diff_err_sweep with a behavioural approximate DUT selected by mode.
// Each sweep is timed from its start edge to the done pulse and the final metrics are checked.
// Outputs are sampled 1 time unit after the rising edge; start is driven between edges.
module tb_abs_diff_err_sweep;

  localparam int OP_W  = 6;
  localparam int CNT_W = 13;
  localparam int SUM_W = 18;

  localparam int M_IDEAL  = 0;
  localparam int M_STUCK0 = 1;
  localparam int M_XOR1   = 2;
  localparam int M_ONEBAD = 3;

  logic              clk;
  logic              rst;
  logic              start;
  logic [11:0]       dut_pi;
  logic [5:0]        dut_po;
  logic              busy;
  logic              done;
  logic [CNT_W-1:0]  err_count;
  logic [SUM_W-1:0]  err_sum;
  logic [5:0]        max_err;
  logic [11:0]       wce_vec;

  int                mode;
  int                checks;
  int                passed;
  int                cyc;
  int                dones;

  abs_diff_err_sweep #(.OP_W(OP_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dut_pi    (dut_pi),
    .dut_po    (dut_po),
    .busy      (busy),
    .done      (done),
    .err_count (err_count),
    .err_sum   (err_sum),
    .max_err   (max_err),
    .wce_vec   (wce_vec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural approximate circuits under evaluation.
  always_comb begin
    logic [5:0] a;
    logic [5:0] b;
    logic [5:0] ex;
    a  = dut_pi[5:0];
    b  = dut_pi[11:6];
    ex = (a >= b) ? (a - b) : (b - a);
    case (mode)
      M_STUCK0: dut_po = 6'd0;
      M_XOR1:   dut_po = ex ^ 6'b000001;
      M_ONEBAD: dut_po = (dut_pi == 12'h5A7) ? (ex ^ 6'b100000) : ex;
      default:  dut_po = ex;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    else passed++;
  endtask

  // Called #1 after a rising edge: raise start so the next edge accepts it.
  task automatic start_edge();
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Count edges until done is seen; optionally pulse start at two cycle indices.
  task automatic wait_done(input int p1, input int p2, output int n, output int nd);
    n  = 0;
    nd = 0;
    while (n < 5000) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        nd++;
        break;
      end
      start = (n == p1) || (n == p2);
    end
    start = 1'b0;
  endtask

  task automatic chk_results(input string tag, input int cnt, input int sum,
                             input int mx, input int vec);
    chk({tag, ".err_count"}, 32'(err_count), cnt);
    chk({tag, ".err_sum"},   32'(err_sum),   sum);
    chk({tag, ".max_err"},   32'(max_err),   mx);
    chk({tag, ".wce_vec"},   32'(wce_vec),   vec);
  endtask

  initial begin
    checks = 0;
    passed = 0;
    mode   = M_IDEAL;
    rst    = 1'b1;
    start  = 1'b0;
    #23;
    chk("rst.dut_pi", 32'(dut_pi), 0);
    chk("rst.busy",   32'(busy),   0);
    chk("rst.done",   32'(done),   0);
    chk_results("rst", 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: ideal DUT
    start_edge();
    chk("s1.busy_after_start", 32'(busy), 1);
    chk("s1.dut_pi_after_start", 32'(dut_pi), 0);
    wait_done(-1, -1, cyc, dones);
    chk("s1.latency", cyc, 4097);
    chk("s1.busy_at_done", 32'(busy), 0);
    chk_results("s1", 0, 0, 0, 0);
    @(posedge clk);
    #1;
    chk("s1.done_drops", 32'(done), 0);

    // 2: stuck at zero
    mode = M_STUCK0;
    start_edge();
    wait_done(-1, -1, cyc, dones);
    chk("s2.latency", cyc, 4097);
    chk_results("s2", 4032, 87360, 63, 12'h03F);
    chk("s2.dut_pi_held", 32'(dut_pi), 12'hFFF);

    // 3: LSB flipped everywhere
    mode = M_XOR1;
    start_edge();
    wait_done(-1, -1, cyc, dones);
    chk("s3.latency", cyc, 4097);
    chk_results("s3", 4096, 4096, 1, 12'h000);

    // 4: single faulty vector
    mode = M_ONEBAD;
    start_edge();
    wait_done(-1, -1, cyc, dones);
    chk("s4.latency", cyc, 4097);
    chk_results("s4", 1, 32, 32, 12'h5A7);

    // 5: asynchronous reset mid-sweep, then a clean ideal sweep
    mode = M_STUCK0;
    start_edge();
    repeat (1000) @(posedge clk);
    #3;
    chk("s5.busy_before_rst", 32'(busy), 1);
    rst = 1'b1;
    #1;
    chk("s5.rst.dut_pi", 32'(dut_pi), 0);
    chk("s5.rst.busy",   32'(busy),   0);
    chk("s5.rst.done",   32'(done),   0);
    chk_results("s5.rst", 0, 0, 0, 0);
    @(negedge clk);
    rst  = 1'b0;
    mode = M_IDEAL;
    @(posedge clk);
    #1;
    chk("s5.idle_busy", 32'(busy), 0);
    start_edge();
    wait_done(-1, -1, cyc, dones);
    chk("s5.latency", cyc, 4097);
    chk_results("s5", 0, 0, 0, 0);

    // 6: start while busy ignored; start in the done cycle restarts and clears
    mode = M_STUCK0;
    start_edge();
    wait_done(10, 2000, cyc, dones);
    chk("s6.latency", cyc, 4097);
    chk("s6.done_count", dones, 1);
    chk_results("s6", 4032, 87360, 63, 12'h03F);
    mode = M_IDEAL;
    start_edge();
    chk("s6.restart.busy",   32'(busy),   1);
    chk("s6.restart.done",   32'(done),   0);
    chk("s6.restart.dut_pi", 32'(dut_pi), 0);
    chk_results("s6.restart", 0, 0, 0, 0);
    wait_done(-1, -1, cyc, dones);
    chk("s6.second_latency", cyc, 4097);
    chk_results("s6.second", 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
